// File: rtl/seq_div32.sv
// seq_div32: restoring 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
// Latency: fixed 33 cycles from the start-sampling edge to the o_valid pulse, special cases included.
// Backpressure: none; i_start is ignored while o_busy=1 and results are held until the next o_valid.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active low
//   i_start      request, sampled only while o_busy=0
//   i_signed     1: two's-complement DIV/REM, 0: unsigned DIVU/REMU
//   i_dividend   dividend, sampled with i_start
//   i_divisor    divisor, sampled with i_start
//   o_busy       division in progress
//   o_valid      one-cycle pulse, o_quotient/o_remainder are new
//   o_quotient   quotient, held until the next o_valid
//   o_remainder  remainder, held until the next o_valid

module seq_div32 #(
  // Width of operands and results. The iteration counter is sized for 32
  // iterations, so 32 is the only supported value.
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Per-operation context captured on the start edge and consumed in FIX.
  typedef struct packed {
    logic             q_neg;    // quotient must be negated
    logic             r_neg;    // remainder must be negated (follows dividend sign)
    logic             div0;     // divisor was zero
    logic [WIDTH-1:0] dvd_raw;  // dividend as presented, returned as remainder on div0
  } op_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       count;

  // Partial remainder is one bit wider than the operands so that the
  // magnitude 2^31 (from -2^31) never drops the borrow of a trial subtract.
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  op_t              op;

  // Start-edge operand preparation.
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  op_t              op_new;

  // Iteration datapath.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             no_borrow;

  // Sign-fixed results presented in FIX.
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_DIV;
      S_DIV:   if (count == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  // Busy covers DIV and FIX, i.e. from the start edge up to the edge that
  // raises o_valid, so a start in the o_valid cycle is accepted.
  always_comb begin
    o_busy = (state != S_IDLE);
  end

  // ------------------------------------------------------------------
  // Operand preparation (used only on the start edge)
  // ------------------------------------------------------------------
  always_comb begin
    dvd_mag = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    dvs_mag = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

    op_new         = '0;
    op_new.q_neg   = i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
    op_new.r_neg   = i_signed & i_dividend[WIDTH-1];
    op_new.div0    = (i_divisor == '0);
    op_new.dvd_raw = i_dividend;
  end

  // ------------------------------------------------------------------
  // One restoring iteration
  // ------------------------------------------------------------------
  // Trial subtract is rem_sh + ~{0,dvs} + 1 over 33 bits; the carry out
  // (bit 33 of the sum) is set exactly when rem_sh >= dvs, i.e. no borrow.
  // rem[WIDTH] is the bit shifted out above rem_sh: if it were ever set the
  // true shifted value would exceed any divisor, so it forces success. After
  // a successful step rem < dvs, so in practice it stays zero.
  always_comb begin
    rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff      = {1'b0, rem_sh} + {1'b0, ~{1'b0, dvs}} + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow = diff[WIDTH+1] | rem[WIDTH];
  end

  // ------------------------------------------------------------------
  // Result sign fix. Divide-by-zero bypasses the sign fix entirely; the
  // -2^31 / -1 overflow needs nothing special since the magnitude quotient
  // 2^31 with q_neg=0 is already 32'h8000_0000.
  // ------------------------------------------------------------------
  always_comb begin
    if (op.div0) begin
      q_fix = '1;
      r_fix = op.dvd_raw;
    end else begin
      q_fix = op.q_neg ? -quo : quo;
      r_fix = op.r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      op          <= '0;
      count       <= '0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            rem   <= '0;
            quo   <= dvd_mag;
            dvs   <= dvs_mag;
            op    <= op_new;
            count <= '0;
          end
        end
        S_DIV: begin
          // quo doubles as the dividend shift register: its MSB feeds rem_sh
          // while the new quotient bit enters at the bottom.
          quo   <= {quo[WIDTH-2:0], no_borrow};
          rem   <= no_borrow ? diff[WIDTH:0] : rem_sh;
          count <= count + 5'd1;
        end
        S_FIX: begin
          o_quotient  <= q_fix;
          o_remainder <= r_fix;
          o_valid     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// tb_seq_div32: self-checking bench for seq_div32.
// Latency: checks the fixed 33-edge start-to-valid latency and 33-cycle busy window.
// Backpressure: checks that starts while busy are ignored and that a start in the valid cycle is accepted.

module tb_seq_div32;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[13];

  seq_div32 dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension division semantics from plain arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int          sa;
    int          sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {q, r};
  endfunction

  // Called at a point 1 time unit after a rising edge; returns 1 unit after
  // the start-sampling edge, with operands scrambled to show they are only
  // needed on that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    i_signed   = s;
    @(posedge i_clk);
    #1;
    i_start    = 1'b0;
    i_dividend = $urandom;
    i_divisor  = $urandom;
    i_signed   = 1'($urandom_range(0, 1));
  endtask

  // Counts edges until o_valid is seen (bounded); lat starts at lat0.
  task automatic wait_valid(input int lat0, output int lat, output int busy_n);
    lat    = lat0;
    busy_n = 0;
    while (!o_valid && lat < lat0 + 40) begin
      if (o_busy) busy_n++;
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er);
    int lat;
    int bn;
    start_op(a, b, s);
    wait_valid(0, lat, bn);
    chk({nm, " quotient"}, o_quotient, eq);
    chk({nm, " remainder"}, o_remainder, er);
    chk({nm, " latency"}, 32'(lat), 32'd33);
    chk({nm, " busy cycles"}, 32'(bn), 32'd33);
    @(posedge i_clk);
    #1;
    chk({nm, " valid one cycle"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          bn;
    int          vcount;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] m;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
    vecs[3]  = '{32'h0000_1234,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h0000_1234};
    vecs[4]  = '{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234};
    vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
    vecs[8]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
    vecs[9]  = '{32'hFFFF_FFF8,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF8};
    vecs[10] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0};
    vecs[11] = '{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0};
    vecs[12] = '{32'd5,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd5};

    // Reset state
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = 32'd0;
    i_divisor  = 32'd0;
    #2;
    chk("reset busy", {31'd0, o_busy}, 32'd0);
    chk("reset valid", {31'd0, o_valid}, 32'd0);
    chk("reset quotient", o_quotient, 32'd0);
    chk("reset remainder", o_remainder, 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r);
    end

    // Start while busy is ignored; start in the valid cycle is back-to-back.
    start_op(32'd1000, 32'd7, 1'b0);
    repeat (9) begin
      @(posedge i_clk);
      #1;
    end
    i_start    = 1'b1;
    i_dividend = 32'd55;
    i_divisor  = 32'd5;
    i_signed   = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_valid(10, lat, bn);
    chk("busy-start latency", 32'(lat), 32'd33);
    chk("busy-start quotient", o_quotient, 32'd142);
    chk("busy-start remainder", o_remainder, 32'd6);
    start_op(32'd55, 32'd5, 1'b0);
    chk("b2b valid pulse ends", {31'd0, o_valid}, 32'd0);
    chk("b2b busy after start", {31'd0, o_busy}, 32'd1);
    wait_valid(0, lat, bn);
    chk("b2b latency", 32'(lat), 32'd33);
    chk("b2b quotient", o_quotient, 32'd11);
    chk("b2b remainder", o_remainder, 32'd0);
    @(posedge i_clk);
    #1;

    // Reset mid-operation aborts with no valid.
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (15) begin
      @(posedge i_clk);
      #1;
    end
    i_reset = 1'b0;
    #1;
    chk("abort busy", {31'd0, o_busy}, 32'd0);
    chk("abort valid", {31'd0, o_valid}, 32'd0);
    chk("abort quotient", o_quotient, 32'd0);
    chk("abort remainder", o_remainder, 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1;
      if (o_valid || o_busy) vcount++;
    end
    chk("abort no activity", 32'(vcount), 32'd0);
    do_op("after abort 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // Randomised operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      s = 1'($urandom_range(0, 1));
      m = ref_div(a, b, s);
      do_op($sformatf("rand%0d %h/%h s=%0d", i, a, b, s), a, b, s, m[63:32], m[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
